// File: rtl/disp_scan.sv
// Four-digit seven-segment scan controller: cycles the digits with a dead-time
// blanking interval before each one and honours a per-digit blank mask.
module disp_scan #(
  parameter int DIV  = 50000,
  parameter int DEAD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [3:0] blank,
  output logic       rd0,
  output logic       rd1,
  output logic       rd2,
  output logic       rd3,
  output logic [6:0] seg_n,
  output logic [1:0] slot,
  output logic       frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DEAD = 2'd1, S_SHOW = 2'd2} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [6:0]    latch_r;
  logic [3:0]    rd_r;
  logic [6:0]    seg_n_r;
  logic [1:0]    slot_r;
  logic          frame_r;
  logic [6:0]    seg_sel_s;
  logic [3:0]    rd_lit_s;

  assign rd0   = rd_r[0];
  assign rd1   = rd_r[1];
  assign rd2   = rd_r[2];
  assign rd3   = rd_r[3];
  assign seg_n = seg_n_r;
  assign slot  = slot_r;
  assign frame = frame_r;

  // Pattern of the current slot's digit and its active-low enable vector.
  always_comb begin
    seg_sel_s = 7'h00;
    case (slot_r)
      2'd0:    seg_sel_s = seg0;
      2'd1:    seg_sel_s = seg1;
      2'd2:    seg_sel_s = seg2;
      2'd3:    seg_sel_s = seg3;
      default: seg_sel_s = 7'h00;
    endcase
    rd_lit_s = ~(4'b0001 << slot_r);
  end

  // Scan state machine with registered digit and segment drives.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      // Disable behaves like reset, except the latched pattern is kept.
      state_r <= S_IDLE;
      cnt_r   <= '0;
      rd_r    <= 4'hF;
      seg_n_r <= 7'h7F;
      slot_r  <= 2'd0;
      frame_r <= 1'b0;
      if (rst) begin
        latch_r <= 7'h00;
      end else begin
        latch_r <= latch_r;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_DEAD;
          cnt_r   <= '0;
          rd_r    <= 4'hF;
          seg_n_r <= 7'h7F;
          slot_r  <= 2'd0;
          frame_r <= 1'b0;
        end
        S_DEAD: begin
          frame_r <= 1'b0;
          cnt_r   <= cnt_r + CNT_ONE;
          if (cnt_r == DEAD_LAST) begin
            // Capture and drive in the same edge so the first lit cycle is correct.
            latch_r <= seg_sel_s;
            state_r <= S_SHOW;
            if (blank[slot_r]) begin
              rd_r    <= 4'hF;
              seg_n_r <= 7'h7F;
            end else begin
              rd_r    <= rd_lit_s;
              seg_n_r <= ~seg_sel_s;
            end
          end else begin
            rd_r    <= 4'hF;
            seg_n_r <= 7'h7F;
          end
        end
        S_SHOW: begin
          frame_r <= 1'b0;
          if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            slot_r  <= slot_r + 2'd1;
            state_r <= S_DEAD;
            rd_r    <= 4'hF;
            seg_n_r <= 7'h7F;
            frame_r <= (slot_r == 2'd3);
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (blank[slot_r]) begin
              rd_r    <= 4'hF;
              seg_n_r <= 7'h7F;
            end else begin
              rd_r    <= rd_lit_s;
              seg_n_r <= ~latch_r;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= '0;
          rd_r    <= 4'hF;
          seg_n_r <= 7'h7F;
          slot_r  <= 2'd0;
          frame_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIV=10, DEAD=2; expected values come from
// the hand-computed scan timetable (cycle n = the cycle after edge n).
module tb_disp_scan;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic [3:0] blank;
  logic       rd0, rd1, rd2, rd3;
  logic [6:0] seg_n;
  logic [1:0] slot;
  logic       frame;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [6:0] exp_n [4];
  logic [3:0] exp_blank;

  disp_scan #(.DIV(10), .DEAD(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .blank(blank),
    .rd0(rd0), .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .seg_n(seg_n), .slot(slot), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected outputs for a scan started at edge k (cycles before k are dark).
  task automatic check_scan(input int k);
    int rel, s, ph;
    logic [3:0] e_rd;
    logic [6:0] e_seg;
    logic [1:0] e_slot;
    logic       e_frame;
    e_rd = 4'hF; e_seg = 7'h7F; e_slot = 2'd0; e_frame = 1'b0;
    rel = cyc - k;
    if (rel >= 0) begin
      s  = (rel / 10) % 4;
      ph = rel % 10;
      e_slot  = 2'(s);
      e_frame = (rel > 0) && (rel % 40 == 0);
      if (ph >= 2 && !exp_blank[s]) begin
        e_rd  = ~(4'b0001 << s);
        e_seg = exp_n[s];
      end
    end
    check("rd", {rd3, rd2, rd1, rd0}, e_rd);
    check("seg_n", seg_n, e_seg);
    check("slot", slot, e_slot);
    check("frame", frame, e_frame);
    check("one_lit", ($countones(~{rd3, rd2, rd1, rd0}) <= 1), 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc = -1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; blank = 4'h0;
    seg0 = 7'h7F; seg1 = 7'h00; seg2 = 7'h00; seg3 = 7'h00;
    exp_blank = 4'h0;
    cyc = -100;

    // Reset held with en=1 keeps everything dark.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd", {rd3, rd2, rd1, rd0}, 4'hF);
      check("rst_seg", seg_n, 7'h7F);
      check("rst_slot", slot, 2'd0);
      check("rst_frame", frame, 1'b0);
    end

    // Scan order, frame pulse and latch behaviour (seg0 changes at cycle 5).
    seg0 = 7'h3F; seg1 = 7'h06; seg2 = 7'h5B; seg3 = 7'h4F;
    exp_n[0] = 7'h40; exp_n[1] = 7'h79; exp_n[2] = 7'h24; exp_n[3] = 7'h30;
    rst = 1'b0;
    cyc = -1;
    while (cyc < 52) begin
      if (cyc == 4) seg0 = 7'h06;
      tick();
      if (cyc >= 40) exp_n[0] = 7'h79;
      check_scan(0);
    end

    // Blank mask on digit 1.
    seg0 = 7'h3F;
    exp_n[0] = 7'h40;
    blank = 4'b0010; exp_blank = 4'b0010;
    do_reset();
    while (cyc < 29) begin
      tick();
      check_scan(0);
    end
    blank = 4'h0; exp_blank = 4'h0;

    // Disable at cycle 25, re-enable at cycle 30.
    do_reset();
    while (cyc < 35) begin
      if (cyc == 24) en = 1'b0;
      if (cyc == 29) en = 1'b1;
      tick();
      if (cyc < 25)       check_scan(0);
      else if (cyc >= 26) check_scan(30);
    end

    // Reset mid-operation at cycle 15, released at cycle 17.
    do_reset();
    while (cyc < 26) begin
      if (cyc == 14) rst = 1'b1;
      if (cyc == 16) rst = 1'b0;
      tick();
      if (cyc < 15)       check_scan(0);
      else if (cyc >= 16) check_scan(17);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
